// File: rtl/exe_mem_pkg.sv
// exe_mem_pkg: control-vector bit map and default payload layout for the EXE->MEM stage
package exe_mem_pkg;
  localparam int CTRL_W = 7;
  localparam int CTRL_MEMREAD = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_READFROMMEM = 4;
  localparam int CTRL_WRITETOMEM = 5;
  localparam int CTRL_R_MEMTOREG = 6;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_ADDR_W = 5;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] result;
    logic [DEF_DATA_W-1:0] rt;
    logic [DEF_REG_ADDR_W-1:0] dst;
    logic [CTRL_W-1:0] ctrl;
  } exe_mem_payload_t;
endpackage

// File: rtl/exe_mem_pipe_reg_slot.sv
// pipe_skid_slot: one payload+valid holding register; clear beats set beats drop.
module pipe_skid_slot #(
  parameter int W = 8,
  parameter int CLR_W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         set_i,
  input  logic         drop_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);
  logic valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    valid_d = clr_i ? 1'b0 : set_i ? 1'b1 : drop_i ? 1'b0 : valid_q;
    data_d = clr_i ? {data_q[W-1:CLR_W], {CLR_W{1'b0}}} : set_i ? d_i : data_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  assign valid_o = valid_q;
  assign q_o = data_q;
endmodule

// File: rtl/exe_mem_pipe_reg.sv
// exe_mem_pipe_reg: EXE->MEM valid/ready pipeline register with flush.
// EXE_MEM_PIPE_REG_SKID_EN adds a skid entry so in_ready comes straight from a flop.
module exe_mem_pipe_reg
  import exe_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W = exe_mem_pkg::CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic [DATA_W-1:0]     in_rt,
  input  logic [REG_ADDR_W-1:0] in_dst,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [DATA_W-1:0]     out_rt,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic [CTRL_W-1:0]     out_ctrl
);
  localparam int PW = 2 * DATA_W + REG_ADDR_W + CTRL_W;
  logic [PW-1:0] in_pl, main_pl;
  logic main_v, in_fire, out_fire;
  assign in_pl = {in_result, in_rt, in_dst, in_ctrl};
  assign in_fire = in_valid & in_ready;
  assign out_fire = main_v & out_ready;
  assign out_valid = main_v;
  assign {out_result, out_rt, out_dst} = main_pl[PW-1:CTRL_W];
  assign out_ctrl = main_pl[CTRL_W-1:0] & {CTRL_W{main_v}};
`ifdef EXE_MEM_PIPE_REG_SKID_EN
  logic [PW-1:0] skid_pl;
  logic skid_v;
  assign in_ready = ~skid_v;
  // a held skid entry always refills the output first, keeping order
  pipe_skid_slot #(.W(PW), .CLR_W(CTRL_W)) u_main (
    .clk(clk), .rst(rst), .clr_i(flush),
    .set_i((out_fire & skid_v) | (in_fire & (~main_v | out_ready))),
    .drop_i(out_fire), .d_i(skid_v ? skid_pl : in_pl),
    .valid_o(main_v), .q_o(main_pl)
  );
  pipe_skid_slot #(.W(PW), .CLR_W(CTRL_W)) u_skid (
    .clk(clk), .rst(rst), .clr_i(flush),
    .set_i(in_fire & main_v & ~out_ready),
    .drop_i(out_fire), .d_i(in_pl),
    .valid_o(skid_v), .q_o(skid_pl)
  );
`else
  assign in_ready = ~main_v | out_ready;
  pipe_skid_slot #(.W(PW), .CLR_W(CTRL_W)) u_main (
    .clk(clk), .rst(rst), .clr_i(flush),
    .set_i(in_fire), .drop_i(out_fire), .d_i(in_pl),
    .valid_o(main_v), .q_o(main_pl)
  );
`endif
endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// tb_exe_mem_pipe_reg: randomized and directed checks against a queue model of the stage
module tb_exe_mem_pipe_reg;
  localparam int DW = 64;
  localparam int RW = 6;
  localparam int CW = 7;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [DW-1:0] in_result = '0, in_rt = '0;
  logic [RW-1:0] in_dst = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic in_ready, out_valid;
  logic [DW-1:0] out_result, out_rt;
  logic [RW-1:0] out_dst;
  logic [CW-1:0] out_ctrl;
  int passed = 0, total = 0;
  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] t;
    logic [RW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;
  beat_t q[$];
  bit m_in, m_out;
  exe_mem_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(RW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rt(in_rt), .in_dst(in_dst), .in_ctrl(in_ctrl),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rt(out_rt), .out_dst(out_dst), .out_ctrl(out_ctrl)
  );
  always #5 clk = ~clk;
  function automatic bit model_rdy();
`ifdef EXE_MEM_PIPE_REG_SKID_EN
    return q.size() < 2;
`else
    return q.size() == 0 || out_ready;
`endif
  endfunction
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk or posedge rst)
    if (rst) q.delete();
    else begin
      m_in = in_valid && model_rdy();
      m_out = q.size() > 0 && out_ready;
      if (flush) q.delete();
      else begin
        if (m_out) void'(q.pop_front());
        if (m_in) q.push_back('{in_result, in_rt, in_dst, in_ctrl});
      end
    end
  always @(negedge clk)
    if (!rst) begin
      chk("m_valid", out_valid, q.size() > 0);
      chk("m_in_ready", in_ready, model_rdy());
      if (q.size() > 0) begin
        chk("m_ctrl", out_ctrl, q[0].c);
        chk("m_result", out_result, q[0].r);
        chk("m_rt", out_rt, q[0].t);
        chk("m_dst", out_dst, q[0].d);
      end else chk("m_ctrl_bubble", out_ctrl, 0);
    end
  initial begin
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_rt", out_rt, 0);
    chk("rst_dst", out_dst, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1;
    in_valid = 1;
    in_result = 64'h10;
    tick();
    chk("stream0", out_result, 64'h10);
    chk("stream0_v", out_valid, 1);
    in_result = 64'h20;
    tick();
    chk("stream1", out_result, 64'h20);
    chk("stream1_v", out_valid, 1);
    in_result = 64'h30;
    tick();
    chk("stream2", out_result, 64'h30);
    chk("stream2_v", out_valid, 1);
    in_valid = 0;
    tick();
    chk("stream_drain_v", out_valid, 0);
    in_valid = 1;
    in_result = 64'hDEADBEEF;
    in_dst = 5;
    in_ctrl = 7'h08;
    tick();
    out_ready = 0;
    in_result = 64'h1111;
    in_dst = 6;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef EXE_MEM_PIPE_REG_SKID_EN
      chk("stall_in_ready", in_ready, i == 0);
`else
      chk("stall_in_ready", in_ready, 0);
`endif
      tick();
      chk("stall_result", out_result, 64'hDEADBEEF);
      chk("stall_dst", out_dst, 5);
      chk("stall_ctrl", out_ctrl, 7'h08);
    end
    out_ready = 1;
    in_valid = 0;
    tick();
`ifdef EXE_MEM_PIPE_REG_SKID_EN
    chk("skid_second_v", out_valid, 1);
    chk("skid_second", out_result, 64'h1111);
    chk("skid_second_dst", out_dst, 6);
    tick();
`endif
    chk("stall_drain_v", out_valid, 0);
    in_valid = 1;
    in_ctrl = 7'h0A;
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    chk("flush_v", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    in_ctrl = 7'h7F;
    tick();
    chk("bubble_ctrl", out_ctrl, 0);
    chk("bubble_v", out_valid, 0);
    in_valid = 1;
    out_ready = 0;
    in_result = 64'hFFFF_0000_1234_5678;
    in_rt = 64'h8765_4321_0000_FFFF;
    in_dst = 33;
    in_ctrl = 7'h0A;
    tick();
    in_valid = 0;
    chk("wide_result", out_result, 64'hFFFF_0000_1234_5678);
    chk("wide_rt", out_rt, 64'h8765_4321_0000_FFFF);
    chk("wide_dst", out_dst, 33);
    chk("pre_rst_v", out_valid, 1);
    #1 rst = 1;
    #1;
    chk("async_rst_v", out_valid, 0);
    chk("async_rst_ctrl", out_ctrl, 0);
    chk("async_rst_result", out_result, 0);
    tick();
    tick();
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 19) == 0;
      in_result = {$urandom, $urandom};
      in_rt = {$urandom, $urandom};
      in_dst = RW'($urandom);
      in_ctrl = CW'($urandom);
      tick();
    end
    in_valid = 0;
    flush = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
